// File: rtl/ssd_decoder_if.sv
// Bus between a multiplexed seven-segment driver (master) and the decoder (slave).
interface ssd_decoder_if;
  logic [6:0] ssd_decoder_port_cc;
  logic [7:0] ssd_decoder_port_anode_control;
  logic [3:0] ssd_decoder_oport_display1;
  logic [3:0] ssd_decoder_oport_display2;
  logic [1:0] ssd_decoder_oport_valid;
  logic       ssd_decoder_oport_update;
  logic       ssd_decoder_oport_error;
  logic       ssd_decoder_oport_frame;

  modport master (
    output ssd_decoder_port_cc,
    output ssd_decoder_port_anode_control,
    input  ssd_decoder_oport_display1,
    input  ssd_decoder_oport_display2,
    input  ssd_decoder_oport_valid,
    input  ssd_decoder_oport_update,
    input  ssd_decoder_oport_error,
    input  ssd_decoder_oport_frame
  );

  modport slave (
    input  ssd_decoder_port_cc,
    input  ssd_decoder_port_anode_control,
    output ssd_decoder_oport_display1,
    output ssd_decoder_oport_display2,
    output ssd_decoder_oport_valid,
    output ssd_decoder_oport_update,
    output ssd_decoder_oport_error,
    output ssd_decoder_oport_frame
  );
endinterface

// File: rtl/ssd_decoder.sv
// Recovers two hex digits from a multiplexed active-low seven-segment bus once a
// cathode/anode pattern has been stable for STABLE_CYCLES samples.
module ssd_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic          ssd_decoder_clk,
  input logic          ssd_decoder_reset_n,
  ssd_decoder_if.slave bus
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {ClsBlank, ClsDigit1, ClsDigit2, ClsIllegal} cls_e;

  logic [14:0] sample_q, sample_d;
  logic [7:0]  run_q, run_d;
  logic        pend_q, pend_d;
  logic [3:0]  disp1_q, disp1_d, disp2_q, disp2_d;
  logic [1:0]  valid_q, valid_d, seen_q, seen_d;
  logic        update_q, update_d, error_q, error_d, frame_q, frame_d;
  cls_e        cls;
  logic [1:0]  sel;
  logic [4:0]  dec;

  // Returns {legal, value} for an active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] cc);
    case (cc)
      7'h40:   seg_decode = 5'h10;
      7'h79:   seg_decode = 5'h11;
      7'h24:   seg_decode = 5'h12;
      7'h30:   seg_decode = 5'h13;
      7'h19:   seg_decode = 5'h14;
      7'h12:   seg_decode = 5'h15;
      7'h02:   seg_decode = 5'h16;
      7'h78:   seg_decode = 5'h17;
      7'h00:   seg_decode = 5'h18;
      7'h10:   seg_decode = 5'h19;
      7'h08:   seg_decode = 5'h1a;
      7'h03:   seg_decode = 5'h1b;
      7'h46:   seg_decode = 5'h1c;
      7'h21:   seg_decode = 5'h1d;
      7'h06:   seg_decode = 5'h1e;
      7'h0e:   seg_decode = 5'h1f;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    sample_d = {bus.ssd_decoder_port_anode_control, bus.ssd_decoder_port_cc};
    if (sample_d != sample_q)   run_d = 8'd1;
    else if (run_q >= StableMax) run_d = run_q;
    else                        run_d = run_q + 8'd1;
    // Fire only on the edge the run first saturates; evaluation happens one edge later.
    pend_d = (run_d == StableMax) && (run_q != StableMax);

    case (sample_q[14:7])
      8'hff:   cls = ClsBlank;
      8'hfe:   cls = ClsDigit1;
      8'hfd:   cls = ClsDigit2;
      default: cls = ClsIllegal;
    endcase
    sel = (cls == ClsDigit1) ? 2'b01 : (cls == ClsDigit2) ? 2'b10 : 2'b00;
    dec = seg_decode(sample_q[6:0]);

    disp1_d  = disp1_q;
    disp2_d  = disp2_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    update_d = 1'b0;
    error_d  = 1'b0;
    frame_d  = 1'b0;

    if (pend_q) begin
      if (cls == ClsIllegal) begin
        error_d = 1'b1;
      end else if (sel != 2'b00) begin
        if (dec[4]) begin
          if (sel[0]) disp1_d = dec[3:0];
          else        disp2_d = dec[3:0];
          valid_d  = valid_q | sel;
          update_d = 1'b1;
          if ((seen_q | sel) == 2'b11) begin
            frame_d = 1'b1;
            seen_d  = 2'b00;
          end else begin
            seen_d = seen_q | sel;
          end
        end else begin
          error_d = 1'b1;
          valid_d = valid_q & ~sel;
        end
      end
    end
  end

  always_ff @(posedge ssd_decoder_clk) begin
    if (!ssd_decoder_reset_n) begin
      sample_q <= '1;
      run_q    <= '0;
      pend_q   <= 1'b0;
      disp1_q  <= '0;
      disp2_q  <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      update_q <= 1'b0;
      error_q  <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      run_q    <= run_d;
      pend_q   <= pend_d;
      disp1_q  <= disp1_d;
      disp2_q  <= disp2_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      update_q <= update_d;
      error_q  <= error_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.ssd_decoder_oport_display1 = disp1_q;
  assign bus.ssd_decoder_oport_display2 = disp2_q;
  assign bus.ssd_decoder_oport_valid    = valid_q;
  assign bus.ssd_decoder_oport_update   = update_q;
  assign bus.ssd_decoder_oport_error    = error_q;
  assign bus.ssd_decoder_oport_frame    = frame_q;

endmodule

// File: tb/tb_ssd_decoder.sv
// Scoreboard bench: the driver predicts pulse events from a run-length model,
// a monitor compares every pulse the decoder presents.
module tb_ssd_decoder;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ssd_decoder_if bus ();

  ssd_decoder #(.STABLE_CYCLES(S)) dut (
    .ssd_decoder_clk     (clk),
    .ssd_decoder_reset_n (reset_n),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [1:0]  v;
    logic        u;
    logic        e;
    logic        f;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [6:0]  cc_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

  // Reference model state
  logic [3:0]  m_d1 = 0, m_d2 = 0;
  logic [1:0]  m_valid = 0, m_seen = 0;
  logic [14:0] prev = '1;
  int          run_len = 0;
  bit          pend = 0;

  task automatic apply_event(input int unsigned edge_n);
    exp_t        x;
    logic [7:0]  an;
    logic [6:0]  cc;
    int          idx;
    int          dig;
    an = prev[14:7];
    cc = prev[6:0];
    idx = -1;
    for (int i = 0; i < 16; i++) if (cc_tab[i] == cc) idx = i;
    dig = (an == 8'hfe) ? 1 : (an == 8'hfd) ? 2 : (an == 8'hff) ? 0 : 3;
    x.u = 0; x.e = 0; x.f = 0;
    if (dig == 3) x.e = 1;
    else if (dig != 0 && idx < 0) begin
      x.e = 1;
      m_valid[dig-1] = 1'b0;
    end else if (dig != 0) begin
      x.u = 1;
      if (dig == 1) m_d1 = 4'(idx); else m_d2 = 4'(idx);
      m_valid[dig-1] = 1'b1;
      m_seen[dig-1] = 1'b1;
      if (m_seen == 2'b11) begin
        x.f = 1;
        m_seen = 0;
      end
    end
    if (dig != 0) begin
      x.edge_n = edge_n; x.d1 = m_d1; x.d2 = m_d2; x.v = m_valid;
      sb.push_back(x);
    end
  endtask

  // Drive one sample for the next rising edge and advance the model by that edge.
  task automatic step(input logic [7:0] an, input logic [6:0] cc, input bit rst);
    @(negedge clk);
    bus.ssd_decoder_port_anode_control = an;
    bus.ssd_decoder_port_cc = cc;
    reset_n = ~rst;
    if (pend && !rst) apply_event(cyc + 1);
    pend = 0;
    if (rst) begin
      run_len = 0; prev = '1;
      m_d1 = 0; m_d2 = 0; m_valid = 0; m_seen = 0;
    end else begin
      if ({an, cc} == prev) run_len++;
      else run_len = 1;
      prev = {an, cc};
      if (run_len == S) pend = 1;
    end
  endtask

  task automatic hold(input logic [7:0] an, input logic [6:0] cc, input int n);
    for (int i = 0; i < n; i++) step(an, cc, 1'b0);
  endtask

  task automatic chk_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ssd_decoder_oport_display1, bus.ssd_decoder_oport_display2,
         bus.ssd_decoder_oport_valid, bus.ssd_decoder_oport_update,
         bus.ssd_decoder_oport_error, bus.ssd_decoder_oport_frame} != 13'h0) begin
      errors++;
      $display("FAIL reset_state: got d1=%h d2=%h v=%b u=%b e=%b f=%b, want all zero",
               bus.ssd_decoder_oport_display1, bus.ssd_decoder_oport_display2,
               bus.ssd_decoder_oport_valid, bus.ssd_decoder_oport_update,
               bus.ssd_decoder_oport_error, bus.ssd_decoder_oport_frame);
    end
  endtask

  // Monitor
  always @(posedge clk) begin
    exp_t x;
    cyc++;
    #1;
    if (bus.ssd_decoder_oport_update || bus.ssd_decoder_oport_error ||
        bus.ssd_decoder_oport_frame) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: edge %0d u=%b e=%b f=%b, want no pulse", cyc,
                 bus.ssd_decoder_oport_update, bus.ssd_decoder_oport_error,
                 bus.ssd_decoder_oport_frame);
      end else begin
        x = sb.pop_front();
        if (x.edge_n != cyc || x.u != bus.ssd_decoder_oport_update ||
            x.e != bus.ssd_decoder_oport_error || x.f != bus.ssd_decoder_oport_frame ||
            x.d1 != bus.ssd_decoder_oport_display1 || x.d2 != bus.ssd_decoder_oport_display2 ||
            x.v != bus.ssd_decoder_oport_valid) begin
          errors++;
          $display("FAIL event: got edge=%0d u=%b e=%b f=%b d1=%h d2=%h v=%b, want edge=%0d u=%b e=%b f=%b d1=%h d2=%h v=%b",
                   cyc, bus.ssd_decoder_oport_update, bus.ssd_decoder_oport_error,
                   bus.ssd_decoder_oport_frame, bus.ssd_decoder_oport_display1,
                   bus.ssd_decoder_oport_display2, bus.ssd_decoder_oport_valid,
                   x.edge_n, x.u, x.e, x.f, x.d1, x.d2, x.v);
        end
      end
    end else if (sb.size() > 0 && sb[0].edge_n <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: edge %0d no pulse, want pulse at edge %0d", cyc,
               sb[0].edge_n);
      void'(sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] an;
    logic [6:0] cc;
    bus.ssd_decoder_port_anode_control = 8'hff;
    bus.ssd_decoder_port_cc = 7'h7f;
    for (int i = 0; i < 3; i++) step(8'hff, 7'h7f, 1'b1);
    chk_reset();

    // Directed scenarios
    hold(8'hfe, 7'h30, 8);
    hold(8'hfd, 7'h12, 108);
    hold(8'hfe, 7'h7f, 8);
    hold(8'hfc, 7'h40, 8);
    hold(8'hff, 7'h7f, 8);
    for (int i = 0; i < 8; i++) hold((i % 2 == 0) ? 8'hfe : 8'hfd, 7'h24, 2);
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 8'hfe : 8'hfd, cc_tab[i], 8);

    // Reset mid-run, then fresh capture
    hold(8'hfe, 7'h79, 3);
    step(8'hfe, 7'h79, 1'b1);
    chk_reset();
    hold(8'hfe, 7'h79, 6);
    // Reset on the edge a capture is due
    hold(8'hfd, 7'h02, 4);
    step(8'hfd, 7'h02, 1'b1);
    hold(8'hfd, 7'h02, 6);

    // Random segments
    for (int n = 0; n < 300; n++) begin
      do begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: an = 8'hfe;
          4, 5, 6:    an = 8'hfd;
          7:          an = 8'hff;
          8:          an = 8'hfc;
          default:    an = 8'($urandom);
        endcase
        if ($urandom_range(0, 9) < 8) cc = cc_tab[$urandom_range(0, 15)];
        else cc = 7'($urandom);
      end while ({an, cc} == prev);
      hold(an, cc, $urandom_range(1, 9));
    end

    hold(8'hff, 7'h7f, 10);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events outstanding, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssd_decoder.md
SSD_DECODER -- requirements
Module: ssd_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples required before capture; legal range 2..255.
REQ-002 SHALL have port ssd_decoder_clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port ssd_decoder_reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port ssd_decoder_port_cc  input  7  cathode pattern, active-low, bit order {g,f,e,d,c,b,a}.
REQ-005 SHALL have port ssd_decoder_port_anode_control  input  8  anode enables, active-low.
REQ-006 SHALL have port ssd_decoder_oport_display1  output  4  last captured value of digit 1 (anode bit 0).
REQ-007 SHALL have port ssd_decoder_oport_display2  output  4  last captured value of digit 2 (anode bit 1).
REQ-008 SHALL have port ssd_decoder_oport_valid  output  2  per-digit valid flags; bit 0 = display1, bit 1 = display2.
REQ-009 SHALL have port ssd_decoder_oport_update  output  1  one-cycle pulse on every successful digit capture.
REQ-010 SHALL have port ssd_decoder_oport_error  output  1  one-cycle pulse on a stable illegal pattern or illegal anode combination.
REQ-011 SHALL have port ssd_decoder_oport_frame  output  1  one-cycle pulse when both digits have been captured since the last frame pulse.

Function
REQ-012 SHALL register {anode_control, cc} into a sample register on every clock edge.
REQ-013 SHALL keep an 8-bit run counter: 1 when the new sample differs from the held sample, +1 when equal, saturating at STABLE_CYCLES.
REQ-014 SHALL evaluate the held sample exactly once per run, on the edge the run counter reaches STABLE_CYCLES; a saturated run SHALL NOT re-trigger.
REQ-015 Latency: with inputs changed before edge E and then held, update/error/display outputs SHALL change on edge E+STABLE_CYCLES.
REQ-016 Classification states: BLANK (all anodes high) -> no action; DIGIT1 (only anode bit 0 low); DIGIT2 (only anode bit 1 low); ILLEGAL (any other combination with at least one low bit).
REQ-017 Decode table (hex value: cc): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E; any other cc is illegal.
REQ-018 DIGIT1/DIGIT2 with legal cc SHALL load the decoded value into the selected display output, set its valid bit, and pulse update for one cycle.
REQ-019 DIGIT1/DIGIT2 with illegal cc SHALL pulse error, clear that digit's valid bit, and leave its display value unchanged.
REQ-020 ILLEGAL anode state SHALL pulse error and change no display or valid bit.
REQ-021 SHALL keep a 2-bit seen mask, setting the bit of each successfully captured digit; when both bits are set, frame SHALL pulse in the same cycle as the completing update and the mask SHALL clear.
REQ-022 A repeat capture of the same digit before the other SHALL NOT pulse frame.
REQ-023 update and error SHALL never be high in the same cycle.
REQ-024 Inputs changing every cycle SHALL produce no update, error or frame pulses.

Reset
REQ-025 While ssd_decoder_reset_n is low at a clock edge: display1=0, display2=0, valid=00, update=0, error=0, frame=0, seen mask=00, run counter=0, sample register=all-ones (blank).
REQ-026 Reset mid-run SHALL discard the run; after release, capture requires a full new STABLE_CYCLES run.
REQ-027 Reset SHALL take priority over any capture due on the same edge.

Verification
REQ-028 Reset, then anode=FE, cc=30 held from before edge E -> at edge E+4 display1=3, valid=01, update high one cycle, frame low.
REQ-029 Then anode=FD, cc=12 held -> display2=5, valid=11, update and frame high one cycle together; held 100 further cycles -> no further pulses.
REQ-030 anode=FE, cc=7F held -> error one cycle, valid bit 0 cleared, display1 unchanged.
REQ-031 anode=FC, cc=40 held -> error one cycle, displays/valid unchanged; anode=FF held -> no pulses.
REQ-032 Alternate FE/FD anodes every 2 cycles (STABLE_CYCLES=4) -> no pulses; every 8 cycles -> update every 8 cycles, frame every second update.
REQ-033 Reset asserted on edge E+3 of a run -> no update; after release a fresh 4-cycle hold captures normally.
